// File: rtl/axis_snoop_arbiter.sv
// axis_snoop_arbiter: packet-atomic round-robin merge of snoop FIFOs onto one registered AXI-Stream master
//   AXIS_ACLK, AXIS_ARESETN : clock, asynchronous active-low reset
//   S_AXIS_*                : NUM_PORTS source streams, port i data at [i*PORT_WIDTH +: PORT_WIDTH]
//   M_AXIS_*                : merged stream, optional one-beat header carrying the source index
//   ARB_GRANT               : one-hot current grant, 0 while idle
//   PKT_COUNT               : packets completed on M_AXIS, wrapping
module axis_snoop_arbiter #(
  parameter int PORT_WIDTH = 8,
  parameter int NUM_PORTS = 4,
  parameter bit HEADER_EN = 1'b1
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_PORTS-1:0]            S_AXIS_TVALID,
  input  logic [NUM_PORTS-1:0]            S_AXIS_TLAST,
  output logic [NUM_PORTS-1:0]            S_AXIS_TREADY,
  output logic [PORT_WIDTH-1:0]           M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [NUM_PORTS-1:0]            ARB_GRANT,
  output logic [15:0]                     PKT_COUNT
);
  localparam int IW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] grant, last_grant, sel;
  logic [IW:0] idx;
  logic [PORT_WIDTH-1:0] src_data;
  logic any_req, out_free, hdr_load, src_hs, src_last;
  assign any_req = |S_AXIS_TVALID;
  assign out_free = ~M_AXIS_TVALID | M_AXIS_TREADY;
  assign src_last = S_AXIS_TLAST[grant];
  // Walk downward so the port nearest last_grant+1 is written last and wins.
  always_comb begin
    sel = last_grant;
    idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = {1'b0, last_grant} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_PORTS)) ? idx - (IW+1)'(NUM_PORTS) : idx;
      sel = S_AXIS_TVALID[idx[IW-1:0]] ? idx[IW-1:0] : sel;
    end
  end
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      src_data = (grant == IW'(i)) ? S_AXIS_TDATA[i*PORT_WIDTH +: PORT_WIDTH] : src_data;
  end
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (any_req ? (HEADER_EN ? HDR : DATA) : IDLE) :
                (state == HDR)  ? (out_free ? DATA : HDR) :
                (src_hs && src_last) ? IDLE : DATA;
  // Ready is gated only by the output register, never by source valid.
  always_comb begin
    hdr_load = (state == HDR) && out_free;
    src_hs = (state == DATA) && out_free && S_AXIS_TVALID[grant];
    ARB_GRANT = (state == IDLE) ? '0 : NUM_PORTS'(1) << grant;
    S_AXIS_TREADY = (state == DATA && out_free) ? NUM_PORTS'(1) << grant : '0;
  end
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) begin
      grant <= '0;
      last_grant <= IW'(NUM_PORTS - 1);
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TLAST <= 1'b0;
      PKT_COUNT <= '0;
    end else begin
      if (state == IDLE && any_req) grant <= sel;
      if (src_hs && src_last) last_grant <= grant;
      if (hdr_load || src_hs) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA <= hdr_load ? PORT_WIDTH'(grant) : src_data;
        M_AXIS_TLAST <= src_hs && src_last;
      end else if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
      if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) PKT_COUNT <= PKT_COUNT + 16'd1;
    end
endmodule

// File: tb/tb_axis_snoop_arbiter.sv
// tb_axis_snoop_arbiter: scoreboard bench for axis_snoop_arbiter with and without header beats
module tb_axis_snoop_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N*W-1:0] s_tdata, s0_tdata;
  logic [N-1:0] s_tvalid, s_tlast, s_tready, s0_tvalid, s0_tlast, s0_tready, grant, grant0;
  logic [W-1:0] m_tdata, m0_tdata;
  logic m_tlast, m_tvalid, m_tready, m0_tlast, m0_tvalid, m0_tready;
  logic [15:0] pkt, pkt0, mcnt, mcnt0;
  logic [W:0] src_mem [N][64];
  logic [W:0] src0_mem [N][64];
  int src_rd [N];
  int src_wr [N];
  int src0_rd [N];
  int src0_wr [N];
  int hs_cnt [N];
  logic [W:0] exp_q [$];
  logic [W:0] exp0_q [$];
  int out_cyc [$];
  int out0_cyc [$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit stall_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [W:0] prev_beat;
  always #5 clk = ~clk;
  axis_snoop_arbiter #(.PORT_WIDTH(W), .NUM_PORTS(N), .HEADER_EN(1'b1)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .ARB_GRANT(grant), .PKT_COUNT(pkt)
  );
  axis_snoop_arbiter #(.PORT_WIDTH(W), .NUM_PORTS(N), .HEADER_EN(1'b0)) dut0 (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA(s0_tdata), .S_AXIS_TVALID(s0_tvalid), .S_AXIS_TLAST(s0_tlast), .S_AXIS_TREADY(s0_tready),
    .M_AXIS_TDATA(m0_tdata), .M_AXIS_TLAST(m0_tlast), .M_AXIS_TVALID(m0_tvalid), .M_AXIS_TREADY(m0_tready),
    .ARB_GRANT(grant0), .PKT_COUNT(pkt0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, want, cyc);
    end
  endtask
  function automatic bit pending();
    for (int p = 0; p < N; p++) if (src_rd[p] != src_wr[p] || src0_rd[p] != src0_wr[p]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic send(input int p, input int n, input logic [W-1:0] base);
    exp_q.push_back({1'b0, W'(p)});
    for (int i = 0; i < n; i++) begin
      src_mem[p][src_wr[p]] = {i == n - 1, base + W'(i)};
      exp_q.push_back({i == n - 1, base + W'(i)});
      src_wr[p]++;
    end
  endtask
  task automatic send0(input int p, input logic [W-1:0] d);
    src0_mem[p][src0_wr[p]] = {1'b1, d};
    exp0_q.push_back({1'b1, d});
    src0_wr[p]++;
  endtask
  task automatic step();
    logic [N-1:0] hs, hs0;
    @(negedge clk);
    for (int p = 0; p < N; p++) begin
      s_tvalid[p] = src_rd[p] != src_wr[p];
      {s_tlast[p], s_tdata[p*W +: W]} = s_tvalid[p] ? src_mem[p][src_rd[p]] : '0;
      s0_tvalid[p] = src0_rd[p] != src0_wr[p];
      {s0_tlast[p], s0_tdata[p*W +: W]} = s0_tvalid[p] ? src0_mem[p][src0_rd[p]] : '0;
    end
    m_tready = stall_mode ? (cyc % 3 == 0) : 1'b1;
    m0_tready = 1'b1;
    #1;
    chk("rdy_onehot", 32'($countones(s_tready) <= 1), 32'd1);
    chk("rdy_full_stall", 32'((m_tvalid && !m_tready) ? s_tready : '0), 32'd0);
    if (prev_stall) chk("hold_stable", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_beat}));
    chk("pkt_cnt", 32'(pkt), 32'(mcnt));
    chk("pkt_cnt0", 32'(pkt0), 32'(mcnt0));
    if (m_tvalid && m_tready) begin
      chk("m_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("m_beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
      out_cyc.push_back(cyc);
      if (m_tlast) mcnt++;
    end
    if (m0_tvalid && m0_tready) begin
      chk("m0_avail", 32'(exp0_q.size() != 0), 32'd1);
      if (exp0_q.size() != 0) chk("m0_beat", 32'({m0_tlast, m0_tdata}), 32'(exp0_q.pop_front()));
      out0_cyc.push_back(cyc);
      if (m0_tlast) mcnt0++;
    end
    hs = s_tvalid & s_tready;
    hs0 = s0_tvalid & s0_tready;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        chk("grant", 32'(grant), 32'(1 << p));
        src_rd[p]++;
        hs_cnt[p]++;
      end
      if (hs0[p]) begin
        chk("grant0", 32'(grant0), 32'(1 << p));
        src0_rd[p]++;
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat = {m_tlast, m_tdata};
    cyc++;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0 || pending()) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 300), 32'd1);
    repeat (2) step();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pkt", 32'(pkt), 32'd0);
    chk("rst_pkt0", 32'(pkt0), 32'd0);
    s_tvalid = '0;
    s0_tvalid = '0;
    exp_q.delete();
    exp0_q.delete();
    for (int p = 0; p < N; p++) begin
      src_rd[p] = src_wr[p];
      src0_rd[p] = src0_wr[p];
    end
    prev_stall = 1'b0;
    mcnt = '0;
    mcnt0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int c0, n, h0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    s0_tdata = '0; s0_tvalid = '0; s0_tlast = '0; m0_tready = 1'b1;
    for (int p = 0; p < N; p++) begin
      src_rd[p] = 0; src_wr[p] = 0; src0_rd[p] = 0; src0_wr[p] = 0; hs_cnt[p] = 0;
    end
    #2;
    do_reset();
    // single packet from port 2: header at +2, payload on consecutive cycles
    send(2, 3, 8'h11);
    src_mem[2][1] = {1'b0, 8'h22};
    src_mem[2][2] = {1'b1, 8'h33};
    exp_q[2] = {1'b0, 8'h22};
    exp_q[3] = {1'b1, 8'h33};
    out_cyc.delete();
    c0 = cyc;
    drain();
    chk("single_beats", 32'(out_cyc.size()), 32'd4);
    for (int i = 0; i < out_cyc.size(); i++) chk("single_timing", 32'(out_cyc[i] - c0), 32'(2 + i));
    chk("single_pkt", 32'(pkt), 32'd1);
    // fairness: every port offers two packets, grants rotate 0..3 twice
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++) send(p, 2, W'(p * 16 + k * 4));
    drain();
    chk("fair_pkt", 32'(pkt), 32'd8);
    // grant hold: port 3 requests while port 0 is mid-packet
    h0 = hs_cnt[0];
    send(0, 4, 8'h70);
    n = 0;
    while (hs_cnt[0] < h0 + 1 && n < 50) begin step(); n++; end
    chk("hold_setup", 32'(n < 50), 32'd1);
    send(3, 2, 8'h80);
    n = 0;
    while (src_rd[0] != src_wr[0] && n < 50) begin
      step();
      chk("hold_rdy3", 32'(s_tready[3]), 32'd0);
      n++;
    end
    drain();
    // backpressure: sink ready pattern 1,0,0 during a 5-beat packet
    stall_mode = 1'b1;
    send(1, 5, 8'h90);
    drain();
    stall_mode = 1'b0;
    // reset mid-packet after two accepted beats; port 0 must win first afterwards
    h0 = hs_cnt[1];
    send(1, 4, 8'h40);
    n = 0;
    while (hs_cnt[1] < h0 + 2 && n < 50) begin step(); n++; end
    chk("rst_setup", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_pre_valid", 32'(m_tvalid), 32'd1);
    do_reset();
    send(0, 1, 8'h50);
    send(2, 1, 8'h60);
    drain();
    // no header: alternating single-beat packets with one idle cycle between
    out0_cyc.delete();
    send0(0, 8'hA0);
    send0(1, 8'hB0);
    send0(0, 8'hA1);
    send0(1, 8'hB1);
    drain();
    chk("nohdr_beats", 32'(out0_cyc.size()), 32'd4);
    for (int i = 1; i < out0_cyc.size(); i++) chk("nohdr_gap", 32'(out0_cyc[i] - out0_cyc[i-1]), 32'd2);
    chk("nohdr_pkt", 32'(pkt0), 32'd4);
    force dut0.PKT_COUNT = 16'hFFFF;
    mcnt0 = 16'hFFFF;
    #1;
    release dut0.PKT_COUNT;
    send0(1, 8'hC0);
    drain();
    chk("pkt_wrap", 32'(pkt0), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/axis_snoop_arbiter.md
# axis_snoop_arbiter

Packet-atomic round-robin arbiter that merges the outputs of up to eight snoop FIFOs into one AXI-Stream master for the shared debug sink (UART/DMA bridge). It grants one source for a whole packet (through TLAST) and optionally prepends a one-beat header carrying the source index. The output stage is registered. Each snoop FIFO already holds only complete packets, so a granted source never stalls mid-packet for lack of data.

## Interface

- PORT_WIDTH, 8, data width of every port; must be >= $clog2(NUM_PORTS)
- NUM_PORTS, 4, number of source ports; legal range 2..8
- HEADER_EN, 1, 1 = prepend header beat per packet, 0 = pass packets unchanged

Ports:

- AXIS_ACLK  in  1  single clock for all logic
- AXIS_ARESETN  in  1  asynchronous, active-low reset
- S_AXIS_TDATA  in  NUM_PORTS*PORT_WIDTH  source data; port i at [i*PORT_WIDTH +: PORT_WIDTH]
- S_AXIS_TVALID  in  NUM_PORTS  per-port valid
- S_AXIS_TLAST  in  NUM_PORTS  per-port last
- S_AXIS_TREADY  out  NUM_PORTS  per-port ready; at most one bit high
- M_AXIS_TDATA  out  PORT_WIDTH  merged data
- M_AXIS_TLAST  out  1  merged last
- M_AXIS_TVALID  out  1  merged valid
- M_AXIS_TREADY  in  1  sink ready
- ARB_GRANT  out  NUM_PORTS  one-hot current grant; 0 in IDLE
- PKT_COUNT  out  16  number of packets completed on M_AXIS; wraps 0xFFFF -> 0

## Operation

- State machine has three states: IDLE, HDR, DATA.
- IDLE:
  - if no S_AXIS_TVALID bit is set, stay in IDLE;
  - otherwise grant the first valid port searching upward from last_grant+1 (modulo NUM_PORTS);
  - register the grant; go to HDR if HEADER_EN=1, else DATA;
  - no beat is accepted in IDLE.
- HDR:
  - when the output register is free, load the header beat: TDATA = zero-extended grant index, TLAST = 0;
  - then go to DATA;
  - S_AXIS_TREADY stays all zero.
- DATA:
  - S_AXIS_TREADY[g] = (~M_AXIS_TVALID | M_AXIS_TREADY); all other bits are 0;
  - each source handshake loads TDATA/TLAST from port g into the output register;
  - a handshake with TLAST=1 sets last_grant <= g, goes to IDLE, and clears ARB_GRANT.
- Output register:
  - free when ~M_AXIS_TVALID | M_AXIS_TREADY;
  - M_AXIS_TVALID sets on a load and clears on a sink handshake with no simultaneous load;
  - TDATA/TLAST hold their value while TVALID=1 and TREADY=0.
- PKT_COUNT increments on each M_AXIS handshake with TLAST=1.
- Valid deasserting on non-granted ports has no effect. The grant never changes mid-packet, even if other ports are valid.
- Granted port dropping TVALID mid-packet: the arbiter waits in DATA with no timeout.

## Timing

- Reset: asynchronous, takes effect immediately on assertion, no clock needed.
  - State = IDLE, last_grant = NUM_PORTS-1 (so port 0 wins first).
  - M_AXIS_TVALID = 0, M_AXIS_TDATA = 0, M_AXIS_TLAST = 0.
  - S_AXIS_TREADY = 0, ARB_GRANT = 0, PKT_COUNT = 0.
- Reset mid-packet: the packet is truncated with no TLAST emitted; the sink is responsible for recovery.
- Latency: a source beat accepted on cycle N is visible on M_AXIS at N+1.
- Header path: a valid request seen in IDLE on cycle N gives the header on M_AXIS at N+2 and the first payload beat at N+3 at the earliest.
- Throughput: 1 beat/cycle inside a packet when M_AXIS_TREADY=1.
- Per-packet overhead: 1 idle cycle (IDLE) plus 1 header cycle if HEADER_EN=1.
- S_AXIS_TREADY depends combinationally on M_AXIS_TREADY, but only through the single granted bit. There is no combinational path from S_AXIS_TVALID to S_AXIS_TREADY.

## Test plan

- **Single packet.** HEADER_EN=1, port 2 sends 3 beats 0x11, 0x22, 0x33 (last), M_TREADY=1.
  - M_AXIS carries 0x02, 0x11, 0x22, 0x33 on consecutive cycles; TLAST only on 0x33.
  - ARB_GRANT = 0b0100 during the packet; PKT_COUNT ends at 1.
- **Round-robin fairness.** All 4 ports continuously offer 2-beat packets.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Header indices on M_AXIS follow the same order; no packet is interleaved.
- **Backpressure.** M_TREADY toggles 1,0,0,1,... during a 5-beat packet from port 1.
  - Every beat appears exactly once, in order, and holds stable while stalled.
  - S_AXIS_TREADY[1] = 0 whenever the output register is full and M_TREADY = 0.
- **Grant hold.** Port 0 is mid-packet when port 3 raises TVALID.
  - S_AXIS_TREADY[3] stays 0 until port 0's TLAST has been accepted.
  - Port 3 is granted on the next arbitration.
- **Reset mid-packet.** AXIS_ARESETN asserted after 2 of 4 beats.
  - All outputs go to their reset values immediately.
  - After release, port 0 wins the first arbitration.
- **HEADER_EN=0, back-to-back single-beat packets.** Ports 0 and 1 alternately send 1-beat packets.
  - No header beats appear; each packet is followed by a 1-cycle gap.
  - PKT_COUNT increments per packet; wrap from 0xFFFF to 0 is checked via a forced preload.
